// File: rtl/dmem_lsu_pipe.sv
// Data memory for the pipelined RV32 core: valid/ready request port,
// base-address window, byte-enable word storage, fault detection and a
// READ_LAT-deep registered response pipeline.
module dmem_lsu_pipe #(
  parameter int          DEPTH_WORDS = 128,
  parameter int          READ_LAT    = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_ls,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_we,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

  // Storage: one word per entry, written lane by lane.
  logic [31:0] mem_q [DEPTH_WORDS];

  // Request decode results.
  logic             accept_s;
  logic [31:0]      off_s;
  logic [31:0]      word_off_s;
  logic             range_bad_s;
  logic             is_w_s, is_h_s, is_b_s, is_uns_s, ls_ok_s;
  logic             misalign_s;
  logic             illegal_s;
  logic             fault_s;
  logic [IDX_W-1:0] idx_s;
  logic [3:0]       be_s;
  logic [31:0]      wlane_s;
  logic             wr_en_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      shifted_s;
  logic [31:0]      load_data_s;

  // Response pipeline stages; the last stage drives the outputs.
  logic [READ_LAT-1:0]       vld_q, vld_d;
  logic [READ_LAT-1:0]       we_q, we_d;
  logic [READ_LAT-1:0]       flt_q, flt_d;
  logic [READ_LAT-1:0][31:0] rdata_q, rdata_d;

  assign req_ready  = ~rst;
  assign accept_s   = req_valid & ~rst;
  assign off_s      = req_addr - BASE_ADDR;
  assign word_off_s = off_s >> 2;

  // Decode access type, range and alignment into a single fault flag.
  always_comb begin
    is_w_s   = 1'b0;
    is_h_s   = 1'b0;
    is_b_s   = 1'b0;
    is_uns_s = 1'b0;
    ls_ok_s  = 1'b1;
    case (req_ls)
      4'b0000: is_w_s = 1'b1;
      4'b1000: is_h_s = 1'b1;
      4'b0100: is_b_s = 1'b1;
      4'b0010: begin
        is_h_s   = 1'b1;
        is_uns_s = 1'b1;
      end
      4'b0001: begin
        is_b_s   = 1'b1;
        is_uns_s = 1'b1;
      end
      default: ls_ok_s = 1'b0;
    endcase
    range_bad_s = (req_addr < BASE_ADDR) | (word_off_s >= DEPTH_W32);
    misalign_s  = (is_w_s & (req_addr[1:0] != 2'b00)) | (is_h_s & req_addr[0]);
    illegal_s   = ~ls_ok_s | (req_we & is_uns_s);
    fault_s     = range_bad_s | misalign_s | illegal_s;
    // Out-of-range requests never touch memory; park the index at 0.
    if (range_bad_s) begin
      idx_s = '0;
    end else begin
      idx_s = word_off_s[IDX_W-1:0];
    end
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    if (is_w_s) begin
      be_s    = 4'b1111;
      wlane_s = req_wdata;
    end else if (is_h_s) begin
      be_s    = req_addr[1] ? 4'b1100 : 4'b0011;
      wlane_s = {2{req_wdata[15:0]}};
    end else if (is_b_s) begin
      be_s    = 4'b0001 << req_addr[1:0];
      wlane_s = {4{req_wdata[7:0]}};
    end else begin
      be_s    = 4'b0000;
      wlane_s = 32'h0000_0000;
    end
    wr_en_s = accept_s & req_we & ~fault_s;
  end

  // Per-byte write port, no reset so contents survive rst.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en_s && be_s[i]) begin
        mem_q[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
      end
    end
  end

  // Lane-select and extend the load word; stores and faults return zero.
  always_comb begin
    rd_word_s = mem_q[idx_s];
    shifted_s = rd_word_s >> {req_addr[1:0], 3'b000};
    if (req_we || fault_s) begin
      load_data_s = 32'h0000_0000;
    end else if (is_w_s) begin
      load_data_s = shifted_s;
    end else if (is_h_s) begin
      load_data_s = is_uns_s ? {16'h0000, shifted_s[15:0]}
                             : {{16{shifted_s[15]}}, shifted_s[15:0]};
    end else if (is_b_s) begin
      load_data_s = is_uns_s ? {24'h00_0000, shifted_s[7:0]}
                             : {{24{shifted_s[7]}}, shifted_s[7:0]};
    end else begin
      load_data_s = 32'h0000_0000;
    end
  end

  // Next-state of the response pipeline: we/fault hold on bubbles, rdata zeroes.
  always_comb begin
    vld_d   = vld_q;
    we_d    = we_q;
    flt_d   = flt_q;
    rdata_d = rdata_q;
    vld_d[0] = accept_s;
    if (accept_s) begin
      we_d[0]    = req_we;
      flt_d[0]   = fault_s;
      rdata_d[0] = load_data_s;
    end else begin
      rdata_d[0] = 32'h0000_0000;
    end
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        we_d[i]    = we_q[i-1];
        flt_d[i]   = flt_q[i-1];
        rdata_d[i] = rdata_q[i-1];
      end else begin
        rdata_d[i] = 32'h0000_0000;
      end
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      we_q    <= '0;
      flt_q   <= '0;
      rdata_q <= '0;
    end else begin
      vld_q   <= vld_d;
      we_q    <= we_d;
      flt_q   <= flt_d;
      rdata_q <= rdata_d;
    end
  end

  assign rsp_valid = vld_q[READ_LAT-1];
  assign rsp_we    = we_q[READ_LAT-1];
  assign rsp_fault = flt_q[READ_LAT-1];
  assign rsp_rdata = rdata_q[READ_LAT-1];

endmodule
